jt51_timer_bank: RTL and testbench
==================================

# jt51_timer_bank

Parametrised bank of `CHANNELS` independent up-counting timers with per-channel start values, auto-reload or one-shot mode, sticky overflow flags and one aggregated, registered interrupt. Sits beside the register interface: it takes start values, mode and control bits from the register file and returns flags, overflow pulses and `irq_n` to the CPU side. It is the generalised successor of the two-channel A/B timer pair. Each channel sees the same width `CW`; narrower timers are padded by the caller in the start value, for example an 8-bit value shifted left by 4.

## Interface
- `CHANNELS`, 2, number of timer channels (≥1)
- `CW`, 12, counter width in bits (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `cen`  in  1  clock enable
- `zero`  in  1  timer tick qualifier; counting advances only on cycles with `cen && zero` (a "tick")
- `start_value`  in  CHANNELS*CW  reload value; channel i at `[i*CW +: CW]`
- `load`  in  CHANNELS  run/start level per channel
- `oneshot`  in  CHANNELS  1 = stop after first overflow; 0 = auto-reload
- `clr_flag`  in  CHANNELS  clears the channel flag; evaluated every `clk`, not gated by tick
- `irq_en`  in  CHANNELS  per-channel interrupt enable
- `flag`  out  CHANNELS  sticky overflow flags
- `overflow`  out  CHANNELS  registered overflow pulse, one `clk` wide
- `count`  out  CHANNELS*CW  current counter values, same packing as `start_value`
- `irq_n`  out  1  registered, active-low interrupt

## Operation
- Per-channel state: `cnt[CW]`, `run`, `last_load`.
- On a tick:
  - `last_load <= load`.
  - If the load rises (`load && !last_load`): `cnt <= start_value`, `run <= 1`. This has priority over everything below.
  - Otherwise, if `!load`: `run <= 0` and `cnt` holds.
  - Otherwise, if `run && cnt != 2^CW-1`: `cnt <= cnt+1`. The arithmetic is modulo 2^CW and no carry is stored.
  - Otherwise, if `run && cnt == 2^CW-1`: this is an overflow event. `cnt <= start_value`. If `oneshot` is set, `run <= 0`.
  - If `!run` with `load` high (a one-shot that has expired): `cnt` holds. Restarting needs `load` low for at least one tick, then high.
- `start_value` is sampled only at a rise of `load` or at an overflow. Changing it mid-count has no effect until one of those.
- `oneshot` is sampled at the overflow event.
- `overflow[i]` is high for exactly the one `clk` cycle that follows the tick edge of an overflow event.
- `flag[i]`, updated every `clk`:
  - If `clr_flag[i]`: `flag <= 0`.
  - Otherwise, on an overflow event edge: `flag <= 1`.
  - Clear wins when both happen in the same cycle. The `overflow` pulse is still emitted in that case.
- `irq_n <= ~|(flag & irq_en)` every `clk`.
- Channels are fully independent. Simultaneous overflows on several channels each set their own flag and pulse in the same cycle.

## Timing
- Reset values: `cnt=0`, `run=0`, `last_load=0`, `flag=0`, `overflow=0`, `count=0`, `irq_n=1`.
- Reset mid-count aborts the count. A `load` held high through reset counts as a new rise on the first tick after reset.
- Let T0 be the tick at which the rise of `load` is taken. The first overflow occurs at tick T0 + (2^CW − start_value).
- Auto-reload period is 2^CW − start_value ticks.
  - `start_value = 2^CW−1` gives an overflow on every tick.
  - `start_value = 0` gives a period of 2^CW ticks.
- `flag` is set at the overflow tick edge.
- `irq_n` falls 1 `clk` after `flag` rises and rises 1 `clk` after `flag` clears or `irq_en` drops.
- `count` is the register itself, with zero latency.
- With `cen` low, or `zero` low, nothing changes except `flag`, `overflow` clearing and `irq_n`.

## Test plan
- **Reset behaviour:** assert `rst` 3 cycles with `load=all 1` → all outputs at their reset values. After release, the first tick loads `start_value`.
- **Auto-reload** (`CW=4`, ch0 `start_value=13`, `irq_en=1`): raise `load`, tick every cycle →
  - `overflow[0]` pulses at ticks 3, 6, 9.
  - `count[0]` sequence is 13, 14, 15, 13.
  - `flag[0]` rises at tick 3 and `irq_n` falls one cycle later.
- **One-shot** (ch1 `start_value=14`, `oneshot=1`): exactly one overflow, at tick 2. `count[1]` then stays at 14. Dropping `load` for 1 tick and raising it again gives the next overflow 2 ticks after the rise.
- **Clear collision:** assert `clr_flag[0]` in the same cycle as an overflow event → `flag[0]` stays 0 and the `overflow[0]` pulse is still seen. Pulse `clr_flag` later → the flag clears and `irq_n` returns to 1 one cycle after.
- **Stall and pause:**
  - Hold `zero=1`, `cen=0` for 10 cycles → `count` is frozen.
  - Drop `load` at `count=14` → `count` holds at 14 with no overflow.
  - Raise `load` again → `count` reloads to `start_value`.
- **Simultaneous channels:** both channels with `start_value=15` → `overflow=2'b11` on the same cycle every tick, and `flag=2'b11`.

Source files
------------

// File: rtl/jt51_timer_bank.sv
// Bank of independent up-counting timers with auto-reload or one-shot mode,
// sticky overflow flags and a registered, active-low aggregated interrupt.
module jt51_timer_bank #(
    parameter int CHANNELS = 2,
    parameter int CW       = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   zero,
    input  logic [CHANNELS*CW-1:0] start_value,
    input  logic [CHANNELS-1:0]    load,
    input  logic [CHANNELS-1:0]    oneshot,
    input  logic [CHANNELS-1:0]    clr_flag,
    input  logic [CHANNELS-1:0]    irq_en,
    output logic [CHANNELS-1:0]    flag,
    output logic [CHANNELS-1:0]    overflow,
    output logic [CHANNELS*CW-1:0] count,
    output logic                   irq_n
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CHANNELS*CW-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]    run_q, run_d;
    logic [CHANNELS-1:0]    last_load_q, last_load_d;
    logic [CHANNELS-1:0]    flag_q, flag_d;
    logic [CHANNELS-1:0]    ovf_q, ovf_d;
    logic                   irq_n_q, irq_n_d;
    logic                   tick;

    assign tick = cen & zero;

    always_comb begin
        cnt_d       = cnt_q;
        run_d       = run_q;
        last_load_d = last_load_q;
        flag_d      = flag_q;
        ovf_d       = '0;
        irq_n_d     = ~|(flag_q & irq_en);
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                last_load_d[i] = load[i];
                if (load[i] && !last_load_q[i]) begin
                    cnt_d[i*CW +: CW] = start_value[i*CW +: CW];
                    run_d[i]          = 1'b1;
                end else if (!load[i]) begin
                    run_d[i] = 1'b0;
                end else if (run_q[i]) begin
                    if (cnt_q[i*CW +: CW] == CNT_MAX) begin
                        ovf_d[i]          = 1'b1;
                        cnt_d[i*CW +: CW] = start_value[i*CW +: CW];
                        if (oneshot[i]) begin
                            run_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + 1'b1;
                    end
                end
            end
            // Software clear beats a same-cycle overflow; the pulse still fires.
            if (clr_flag[i]) begin
                flag_d[i] = 1'b0;
            end else if (ovf_d[i]) begin
                flag_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            run_q       <= '0;
            last_load_q <= '0;
            flag_q      <= '0;
            ovf_q       <= '0;
            irq_n_q     <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            last_load_q <= last_load_d;
            flag_q      <= flag_d;
            ovf_q       <= ovf_d;
            irq_n_q     <= irq_n_d;
        end
    end

    assign count    = cnt_q;
    assign flag     = flag_q;
    assign overflow = ovf_q;
    assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_jt51_timer_bank.sv
// Directed and randomized bench for jt51_timer_bank (2 channels, 4-bit counters)
// against a ticks-remaining reference model.
module tb_jt51_timer_bank;

    localparam int CH   = 2;
    localparam int CW   = 4;
    localparam int FULL = 1 << CW;

    logic              clk = 1'b0;
    logic              rst;
    logic              cen;
    logic              zero;
    logic [CH*CW-1:0]  start_value;
    logic [CH-1:0]     load;
    logic [CH-1:0]     oneshot;
    logic [CH-1:0]     clr_flag;
    logic [CH-1:0]     irq_en;
    logic [CH-1:0]     flag;
    logic [CH-1:0]     overflow;
    logic [CH*CW-1:0]  count;
    logic              irq_n;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: ticks left until the next overflow, plus run/level state.
    int m_left [CH];
    bit m_run  [CH];
    bit m_prev [CH];
    bit m_flag [CH];
    bit m_ovf  [CH];
    bit m_irq_n;

    jt51_timer_bank #(.CHANNELS(CH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .zero        (zero),
        .start_value (start_value),
        .load        (load),
        .oneshot     (oneshot),
        .clr_flag    (clr_flag),
        .irq_en      (irq_en),
        .flag        (flag),
        .overflow    (overflow),
        .count       (count),
        .irq_n       (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sv_of(int i);
        logic [CH*CW-1:0] v;
        v = start_value;
        return int'(v[i*CW +: CW]);
    endfunction

    function automatic logic [CW-1:0] m_count(int i);
        return CW'(FULL - m_left[i]);
    endfunction

    task automatic model_edge();
        bit any;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_left[i] = FULL;
                m_run[i]  = 0;
                m_prev[i] = 0;
                m_flag[i] = 0;
                m_ovf[i]  = 0;
            end
            m_irq_n = 1;
            return;
        end
        any = 0;
        for (int i = 0; i < CH; i++) any |= m_flag[i] & irq_en[i];
        m_irq_n = !any;
        for (int i = 0; i < CH; i++) begin
            m_ovf[i] = 0;
            if (cen && zero) begin
                if (load[i] && !m_prev[i]) begin
                    m_left[i] = FULL - sv_of(i);
                    m_run[i]  = 1;
                end else if (!load[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ovf[i]  = 1;
                        m_left[i] = FULL - sv_of(i);
                        if (oneshot[i]) m_run[i] = 0;
                    end
                end
                m_prev[i] = load[i];
            end
            if (clr_flag[i]) m_flag[i] = 0;
            else if (m_ovf[i]) m_flag[i] = 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("count[%0d]", i), 32'(count[i*CW +: CW]), 32'(m_count(i)));
            chk($sformatf("flag[%0d]", i), 32'(flag[i]), 32'(m_flag[i]));
            chk($sformatf("overflow[%0d]", i), 32'(overflow[i]), 32'(m_ovf[i]));
        end
        chk("irq_n", 32'(irq_n), 32'(m_irq_n));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1;
        repeat (cycles) step();
        rst = 0;
    endtask

    initial begin
        int k;
        int ovf_seen;
        rst         = 1;
        cen         = 1;
        zero        = 1;
        start_value = {4'd14, 4'd13};
        load        = 2'b11;
        oneshot     = 2'b00;
        clr_flag    = 2'b00;
        irq_en      = 2'b00;

        // Reset with load held high; first tick afterwards loads start_value
        do_reset(3);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_irq_n", 32'(irq_n), 32'h1);
        step();
        chk("post_reset_load", 32'(count), 32'hE_D);

        // Auto-reload on ch0, start 13: overflow at ticks 3, 6, 9
        load = 2'b00;
        do_reset(1);
        irq_en = 2'b01;
        load   = 2'b01;
        ovf_seen = 0;
        for (int t = 0; t <= 9; t++) begin
            step();
            chk($sformatf("ar_ovf_t%0d", t), 32'(overflow[0]),
                32'((t > 0) && (t % 3 == 0)));
            if (t == 3) chk("ar_flag_t3", 32'(flag[0]), 32'h1);
            if (t == 4) chk("ar_irq_t4", 32'(irq_n), 32'h0);
        end
        chk("ar_count_seq", 32'(count[3:0]), 32'd13);

        // One-shot on ch1, start 14: single overflow at tick 2, then hold
        oneshot[1] = 1;
        load[1]    = 1;
        for (int t = 0; t <= 6; t++) begin
            step();
            chk($sformatf("os_ovf_t%0d", t), 32'(overflow[1]), 32'(t == 2));
        end
        chk("os_hold", 32'(count[7:4]), 32'd14);
        load[1] = 0;
        step();
        load[1] = 1;
        for (int t = 0; t <= 3; t++) begin
            step();
            chk($sformatf("os_re_ovf_t%0d", t), 32'(overflow[1]), 32'(t == 2));
        end
        load[1] = 0;

        // Clear collides with an overflow on ch0
        clr_flag[0] = 1;
        step();
        clr_flag[0] = 0;
        k = 0;
        while (m_left[0] != 1 && k < 40) begin step(); k++; end
        chk("clr_wait_bound", 32'(k < 40), 32'h1);
        clr_flag[0] = 1;
        step();
        clr_flag[0] = 0;
        chk("clr_coll_flag", 32'(flag[0]), 32'h0);
        chk("clr_coll_ovf", 32'(overflow[0]), 32'h1);
        k = 0;
        while (flag[0] !== 1'b1 && k < 40) begin step(); k++; end
        chk("flag_set_bound", 32'(k < 40), 32'h1);
        step();
        chk("irq_low", 32'(irq_n), 32'h0);
        clr_flag[0] = 1;
        step();
        clr_flag[0] = 0;
        chk("clr_flag0", 32'(flag[0]), 32'h0);
        step();
        chk("irq_back", 32'(irq_n), 32'h1);

        // Stall with cen low, then pause via load at count 14, then reload
        cen = 0;
        repeat (10) step();
        cen = 1;
        k = 0;
        while (m_count(0) != 4'd14 && k < 40) begin step(); k++; end
        chk("pause_wait_bound", 32'(k < 40), 32'h1);
        load[0] = 0;
        repeat (5) step();
        chk("pause_hold", 32'(count[3:0]), 32'd14);
        load[0] = 1;
        step();
        chk("reload", 32'(count[3:0]), 32'd13);

        // Both channels at 15: overflow on every tick together
        load        = 2'b00;
        oneshot     = 2'b00;
        start_value = {4'd15, 4'd15};
        step();
        load = 2'b11;
        step();
        for (int t = 0; t < 4; t++) begin
            step();
            chk("sim_ovf", 32'(overflow), 32'h3);
            chk("sim_flag", 32'(flag), 32'h3);
        end

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            rst  = ($urandom_range(0, 199) == 0);
            cen  = ($urandom_range(0, 9) < 8);
            zero = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 9) == 0) load[i] = ~load[i];
                if ($urandom_range(0, 19) == 0) oneshot[i] = ~oneshot[i];
                clr_flag[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 19) == 0) irq_en[i] = ~irq_en[i];
            end
            if ($urandom_range(0, 19) == 0)
                start_value = CH*CW'($urandom_range(0, (1 << (CH*CW)) - 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
